// File: rtl/cpu_result_scanner.sv
// Readback checker for the RISC_V_CPU debug port: walks words lane by lane (MSB lane first),
// compares value_o against an expected-byte stream. Optional: CPU_RESULT_SCANNER_STOP_ON_ERR_EN.
module cpu_result_scanner #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 8,
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              start,
  input  logic              sel_data,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              exp_valid,
  input  logic [DATA_W-1:0] exp_data,
  output logic              exp_ready,
  input  logic [DATA_W-1:0] value_o,
  output logic              DataOrReg,
  output logic [ADDR_W-1:0] address,
  output logic [LANE_W-1:0] vout_addr,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  byte_idx
);

`ifdef CPU_RESULT_SCANNER_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAT_MAX  = LAT_W'(RD_LAT - 1);
  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(LANES - 1);
  localparam logic [CNT_W-1:0]  ERR_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CMP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  logic [LAT_W-1:0]  lat_cnt;
  logic [CNT_W-1:0]  words_left;
  logic              bad_byte;
  logic              last_byte;

  assign exp_ready = (state == S_CMP);
  assign bad_byte  = (value_o != exp_data);
  // words_left counts the current word too, so 1 means this is the final word
  assign last_byte = (vout_addr == '0) && (words_left == CNT_W'(1));

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state      <= S_IDLE;
      lat_cnt    <= '0;
      words_left <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mismatch   <= 1'b0;
      err_count  <= '0;
      byte_idx   <= '0;
      address    <= '0;
      vout_addr  <= LANE_MAX;
      DataOrReg  <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            DataOrReg  <= sel_data;
            address    <= base_addr;
            vout_addr  <= LANE_MAX;
            words_left <= num_words;
            err_count  <= '0;
            byte_idx   <= '0;
            lat_cnt    <= '0;
            if (num_words == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_WAIT;
              done  <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end

        S_WAIT: begin
          if (lat_cnt == LAT_MAX) begin
            state   <= S_CMP;
            lat_cnt <= '0;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end

        S_CMP: begin
          if (exp_valid) begin
            if (bad_byte) begin
              mismatch <= 1'b1;
              if (err_count != ERR_MAX) begin
                err_count <= err_count + 1'b1;
              end
            end
            if (bad_byte && STOP_ON_ERR) begin
              // selects and byte_idx stay on the failing byte for inspection
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              if (last_byte) begin
                state <= S_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= S_WAIT;
                if (vout_addr == '0) begin
                  vout_addr  <= LANE_MAX;
                  address    <= address + 1'b1;
                  words_left <= words_left - 1'b1;
                end else begin
                  vout_addr <= vout_addr - 1'b1;
                end
              end
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
